// File: rtl/serial_rx_8n1_pkg.sv
// Shared definitions for the 8N1 serial line: state encodings, default bit timing and idle level.
// A future transmitter imports the same package so both ends agree on the wire format.
package serial_rx_8n1_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/serial_rx_8n1_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a configurable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_rx_8n1.sv
// 8N1 serial receiver: synchronizes the line, samples each bit at mid-bit and
// presents every good byte with a one-cycle strobe; bad stop bits raise frame_err.
module serial_rx_8n1
  import serial_rx_8n1_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  rx_state_t            state;
  logic                 rx_s;
  logic [CNT_W-1:0]     clk_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;

  sync_2ff #(.RESET_VAL(LINE_IDLE)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_in),
    .q     (rx_s)
  );

  // START burns half a bit so every later sample lands one full bit further, at mid-bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      clk_cnt    <= clk_cnt + 1'b1;
      unique case (state)
        ST_IDLE: begin
          clk_cnt <= '0;
          if (rx_s != LINE_IDLE) begin
            state <= ST_START;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            if (rx_s == LINE_IDLE) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
        end
        ST_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) state <= ST_STOP;
            else bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (rx_s == LINE_IDLE) begin
              data_out   <= shift;
              data_valid <= 1'b1;
              state      <= ST_IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_WAIT_HIGH;
            end
          end
        end
        // A held-low break must release before another start bit can be seen.
        ST_WAIT_HIGH: begin
          clk_cnt <= '0;
          if (rx_s == LINE_IDLE) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          clk_cnt <= '0;
          state   <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx_8n1.sv
// Self-checking bench for serial_rx_8n1: frame-level model predicts each strobe's cycle and byte,
// compared against the DUT every cycle, plus literal spot checks on busy and counts.
module tb_serial_rx_8n1;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int LAT = 2 + CPB / 2 + (DB + 1) * CPB;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         due;
    bit         is_err;
    logic [7:0] data;
  } frame_event_t;

  frame_event_t pending[$];
  logic [7:0]   model_data = 8'h00;
  logic         exp_valid;
  logic         exp_err;
  int           valid_count    = 0;
  int           err_count      = 0;
  int           last_valid_cyc = -1;
  int           start_cyc;

  serial_rx_8n1 #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame bit-accurately and tells the model when and what the receiver must report.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    logic [9:0]   frame;
    frame_event_t ev;
    frame     = {stop_bit, b, 1'b0};
    ev.due    = cyc + 1 + LAT;
    ev.is_err = (stop_bit != 1'b1);
    ev.data   = b;
    pending.push_back(ev);
    for (int i = 0; i < 10; i++) begin
      rx_in = frame[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      pending.delete();
      model_data = 8'h00;
      checkOutput("reset data_out", data_out, 0);
      checkOutput("reset data_valid", data_valid, 0);
      checkOutput("reset frame_err", frame_err, 0);
      checkOutput("reset busy", busy, 0);
    end else begin
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (pending.size() > 0 && pending[0].due == cyc) begin
        if (pending[0].is_err) exp_err = 1'b1;
        else begin
          exp_valid  = 1'b1;
          model_data = pending[0].data;
        end
        void'(pending.pop_front());
      end
      checkOutput("data_valid", data_valid, exp_valid);
      checkOutput("frame_err", frame_err, exp_err);
      checkOutput("data_out", data_out, model_data);
    end
    if (data_valid === 1'b1) begin
      valid_count++;
      last_valid_cyc = cyc;
    end
    if (frame_err === 1'b1) err_count++;
  end

  initial begin
    $display("[TB] serial_rx_8n1 bench start");

    rst_n = 1'b0;
    rx_in = 1'b1;
    idleCycles(3);
    checkOutput("t1 busy", busy, 0);
    checkOutput("t1 data_out", data_out, 0);
    checkOutput("t1 data_valid", data_valid, 0);
    checkOutput("t1 frame_err", frame_err, 0);
    rst_n = 1'b1;
    idleCycles(5);

    // Start edge is the posedge after start_cyc; valid follows 154 cycles later.
    start_cyc = cyc;
    applyStimulus(8'hA5, 1'b1);
    idleCycles(10);
    checkOutput("t2 data_out", data_out, 8'hA5);
    checkOutput("t2 latency", last_valid_cyc - start_cyc, 155);
    checkOutput("t2 valid count", valid_count, 1);
    checkOutput("t2 err count", err_count, 0);

    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    idleCycles(10);
    checkOutput("t3 data_out", data_out, 8'hFF);
    checkOutput("t3 valid count", valid_count, 3);

    rx_in = 1'b0;
    idleCycles(4);
    rx_in = 1'b1;
    idleCycles(2);
    checkOutput("t4 busy during glitch", busy, 1);
    idleCycles(12);
    checkOutput("t4 busy after glitch", busy, 0);
    checkOutput("t4 valid count", valid_count, 3);
    checkOutput("t4 err count", err_count, 0);

    applyStimulus(8'h3C, 1'b0);
    idleCycles(40);
    checkOutput("t5 busy while low", busy, 1);
    checkOutput("t5 data_out kept", data_out, 8'hFF);
    checkOutput("t5 err count", err_count, 1);
    rx_in = 1'b1;
    idleCycles(5);
    checkOutput("t5 busy after release", busy, 0);
    applyStimulus(8'h81, 1'b1);
    idleCycles(10);
    checkOutput("t5 data_out", data_out, 8'h81);
    checkOutput("t5 valid count", valid_count, 4);

    // Reset is held through the rest of the aborted frame so its data bits cannot look like a start.
    fork
      applyStimulus(8'h5A, 1'b1);
      begin
        idleCycles(60);
        checkOutput("t6 busy in data", busy, 1);
        idleCycles(4);
        rst_n = 1'b0;
        idleCycles(2);
        checkOutput("t6 busy in reset", busy, 0);
        checkOutput("t6 data_out in reset", data_out, 0);
      end
    join
    idleCycles(4);
    rst_n = 1'b1;
    idleCycles(10);
    checkOutput("t6 valid count after abort", valid_count, 4);
    applyStimulus(8'h12, 1'b1);
    idleCycles(10);
    checkOutput("t6 data_out", data_out, 8'h12);
    checkOutput("t6 valid count", valid_count, 5);
    checkOutput("t6 err count", err_count, 1);
    checkOutput("pending empty", pending.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
